// File: rtl/bus_mem_sys.sv
`default_nettype none
// ============================================================================
// Module  : bus_mem_sys
// Brief   : 4-master round-robin shared bus with 8 slave selects; slave 0 is
//           an internal memory.
// Revision: 1.0 - initial release
// ============================================================================
module bus_mem_sys #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 4096
`ifdef MEM_INIT_EN
  , parameter MEM_INIT_FILE = "mem.hex"
`endif
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  master_0_req,
  input  logic                  master_0_as,
  input  logic [ADDR_WIDTH-1:0] master_0_addr,
  input  logic                  master_0_wr,
  input  logic [DATA_WIDTH-1:0] master_0_wr_data,
  output logic                  master_0_grnt,
  input  logic                  master_1_req,
  input  logic                  master_1_as,
  input  logic [ADDR_WIDTH-1:0] master_1_addr,
  input  logic                  master_1_wr,
  input  logic [DATA_WIDTH-1:0] master_1_wr_data,
  output logic                  master_1_grnt,
  input  logic                  master_2_req,
  input  logic                  master_2_as,
  input  logic [ADDR_WIDTH-1:0] master_2_addr,
  input  logic                  master_2_wr,
  input  logic [DATA_WIDTH-1:0] master_2_wr_data,
  output logic                  master_2_grnt,
  input  logic                  master_3_req,
  input  logic                  master_3_as,
  input  logic [ADDR_WIDTH-1:0] master_3_addr,
  input  logic                  master_3_wr,
  input  logic [DATA_WIDTH-1:0] master_3_wr_data,
  output logic                  master_3_grnt,
  output logic                  slave_as,
  output logic [ADDR_WIDTH-1:0] slave_addr,
  output logic                  slave_wr,
  output logic [DATA_WIDTH-1:0] slave_wr_data,
  output logic                  slave_1_cs,
  output logic                  slave_2_cs,
  output logic                  slave_3_cs,
  output logic                  slave_4_cs,
  output logic                  slave_5_cs,
  output logic                  slave_6_cs,
  output logic                  slave_7_cs,
  input  logic                  slave_1_rdy,
  input  logic                  slave_2_rdy,
  input  logic                  slave_3_rdy,
  input  logic                  slave_4_rdy,
  input  logic                  slave_5_rdy,
  input  logic                  slave_6_rdy,
  input  logic                  slave_7_rdy,
  input  logic [DATA_WIDTH-1:0] slave_1_out_data,
  input  logic [DATA_WIDTH-1:0] slave_2_out_data,
  input  logic [DATA_WIDTH-1:0] slave_3_out_data,
  input  logic [DATA_WIDTH-1:0] slave_4_out_data,
  input  logic [DATA_WIDTH-1:0] slave_5_out_data,
  input  logic [DATA_WIDTH-1:0] slave_6_out_data,
  input  logic [DATA_WIDTH-1:0] slave_7_out_data,
  output logic                  master_rdy,
  output logic [DATA_WIDTH-1:0] master_data
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);

  logic [3:0]            req;
  logic                  as_v    [4];
  logic [ADDR_WIDTH-1:0] addr_v  [4];
  logic                  wr_v    [4];
  logic [DATA_WIDTH-1:0] wdata_v [4];
  logic [7:0]            rdy_v;
  logic [DATA_WIDTH-1:0] data_v  [8];

  logic [1:0]            owner_q, owner_d, cand;
  logic                  found;
  logic                  as_q, as_d;
  logic [2:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] mem_rd_q, mem_rd_d;
  logic [2:0]            idx;
  logic                  cs0;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign req        = {master_3_req, master_2_req, master_1_req, master_0_req};
  assign as_v[0]    = master_0_as;      assign as_v[1]    = master_1_as;
  assign as_v[2]    = master_2_as;      assign as_v[3]    = master_3_as;
  assign addr_v[0]  = master_0_addr;    assign addr_v[1]  = master_1_addr;
  assign addr_v[2]  = master_2_addr;    assign addr_v[3]  = master_3_addr;
  assign wr_v[0]    = master_0_wr;      assign wr_v[1]    = master_1_wr;
  assign wr_v[2]    = master_2_wr;      assign wr_v[3]    = master_3_wr;
  assign wdata_v[0] = master_0_wr_data; assign wdata_v[1] = master_1_wr_data;
  assign wdata_v[2] = master_2_wr_data; assign wdata_v[3] = master_3_wr_data;

  assign master_0_grnt = (owner_q == 2'd0);
  assign master_1_grnt = (owner_q == 2'd1);
  assign master_2_grnt = (owner_q == 2'd2);
  assign master_3_grnt = (owner_q == 2'd3);

  assign slave_as      = as_v[owner_q];
  assign slave_addr    = addr_v[owner_q];
  assign slave_wr      = wr_v[owner_q];
  assign slave_wr_data = wdata_v[owner_q];

  assign idx        = slave_addr[ADDR_WIDTH-1 -: 3];
  assign cs0        = slave_as && (idx == 3'd0);
  assign slave_1_cs = slave_as && (idx == 3'd1);
  assign slave_2_cs = slave_as && (idx == 3'd2);
  assign slave_3_cs = slave_as && (idx == 3'd3);
  assign slave_4_cs = slave_as && (idx == 3'd4);
  assign slave_5_cs = slave_as && (idx == 3'd5);
  assign slave_6_cs = slave_as && (idx == 3'd6);
  assign slave_7_cs = slave_as && (idx == 3'd7);

  // Internal memory always completes in one cycle, so its ready is tied high.
  assign rdy_v = {slave_7_rdy, slave_6_rdy, slave_5_rdy, slave_4_rdy,
                  slave_3_rdy, slave_2_rdy, slave_1_rdy, 1'b1};
  assign data_v[0] = mem_rd_q;         assign data_v[1] = slave_1_out_data;
  assign data_v[2] = slave_2_out_data; assign data_v[3] = slave_3_out_data;
  assign data_v[4] = slave_4_out_data; assign data_v[5] = slave_5_out_data;
  assign data_v[6] = slave_6_out_data; assign data_v[7] = slave_7_out_data;

  assign master_rdy  = as_q && rdy_v[sel_q];
  assign master_data = as_q ? data_v[sel_q] : '0;

  always_comb begin
    owner_d  = owner_q;
    cand     = owner_q;
    found    = 1'b0;
    as_d     = slave_as;
    sel_d    = idx;
    mem_rd_d = mem_rd_q;
    // Owner is held while requesting; otherwise first requester after it wins.
    if (!req[owner_q]) begin
      for (int i = 1; i < 4; i++) begin
        cand = owner_q + 2'(i);
        if (!found && req[cand]) begin
          owner_d = cand;
          found   = 1'b1;
        end
      end
    end
    if (cs0 && slave_wr) begin
      mem_rd_d = mem[slave_addr[MEM_AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      owner_q  <= 2'd0;
      as_q     <= 1'b0;
      sel_q    <= 3'd0;
      mem_rd_q <= '0;
    end else begin
      owner_q  <= owner_d;
      as_q     <= as_d;
      sel_q    <= sel_d;
      mem_rd_q <= mem_rd_d;
    end
  end

  // Memory array is deliberately not reset; writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (!rst_ && cs0 && !slave_wr) begin
      mem[slave_addr[MEM_AW-1:0]] <= slave_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_sys.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_mem_sys
// Brief   : Directed self-checking bench for bus_mem_sys.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_mem_sys;

  logic        clk = 1'b0;
  logic        rst_;
  logic [3:0]  req, as_m, wr_m;
  logic [29:0] addr_m [4];
  logic [31:0] wdat_m [4];
  logic        slave_5_rdy;
  wire  [3:0]  grnt;
  wire  [7:1]  cs;
  wire         slave_as, slave_wr, master_rdy;
  wire  [29:0] slave_addr;
  wire  [31:0] slave_wr_data, master_data;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  bus_mem_sys dut (
    .clk(clk), .rst_(rst_),
    .master_0_req(req[0]), .master_0_as(as_m[0]), .master_0_addr(addr_m[0]),
    .master_0_wr(wr_m[0]), .master_0_wr_data(wdat_m[0]), .master_0_grnt(grnt[0]),
    .master_1_req(req[1]), .master_1_as(as_m[1]), .master_1_addr(addr_m[1]),
    .master_1_wr(wr_m[1]), .master_1_wr_data(wdat_m[1]), .master_1_grnt(grnt[1]),
    .master_2_req(req[2]), .master_2_as(as_m[2]), .master_2_addr(addr_m[2]),
    .master_2_wr(wr_m[2]), .master_2_wr_data(wdat_m[2]), .master_2_grnt(grnt[2]),
    .master_3_req(req[3]), .master_3_as(as_m[3]), .master_3_addr(addr_m[3]),
    .master_3_wr(wr_m[3]), .master_3_wr_data(wdat_m[3]), .master_3_grnt(grnt[3]),
    .slave_as(slave_as), .slave_addr(slave_addr), .slave_wr(slave_wr),
    .slave_wr_data(slave_wr_data),
    .slave_1_cs(cs[1]), .slave_2_cs(cs[2]), .slave_3_cs(cs[3]), .slave_4_cs(cs[4]),
    .slave_5_cs(cs[5]), .slave_6_cs(cs[6]), .slave_7_cs(cs[7]),
    .slave_1_rdy(1'b1), .slave_2_rdy(1'b1), .slave_3_rdy(1'b1), .slave_4_rdy(1'b1),
    .slave_5_rdy(slave_5_rdy), .slave_6_rdy(1'b1), .slave_7_rdy(1'b1),
    .slave_1_out_data(32'd1), .slave_2_out_data(32'd2), .slave_3_out_data(32'd3),
    .slave_4_out_data(32'd4), .slave_5_out_data(32'd5), .slave_6_out_data(32'd6),
    .slave_7_out_data(32'd7),
    .master_rdy(master_rdy), .master_data(master_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m3(input logic as_i, input logic wr_i, input logic [29:0] a, input logic [31:0] d);
    as_m[3]   = as_i;
    wr_m[3]   = wr_i;
    addr_m[3] = a;
    wdat_m[3] = d;
  endtask

  initial begin
    rst_ = 1'b1; req = '0; as_m = '0; wr_m = '0; slave_5_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_m[i] = '0;
      wdat_m[i] = '0;
    end
    #12;
    // T1 reset
    check("rst_grnt", {28'd0, grnt}, 32'h1);
    check("rst_rdy",  {31'd0, master_rdy}, 32'h0);
    check("rst_data", master_data, 32'h0);
    tick();
    rst_ = 1'b0;

    // T2 round-robin handover
    req = 4'b1110; tick(); check("rr_m1", {28'd0, grnt}, 32'h2);
    req = 4'b1100; tick(); check("rr_m2", {28'd0, grnt}, 32'h4);
    req = 4'b1000; tick(); check("rr_m3", {28'd0, grnt}, 32'h8);

    // T3 external slave decode
    m3(1'b1, 1'b1, 30'h0800_0000, 32'h0); #1;
    check("cs_s1", {25'd0, cs}, 32'h01);
    tick();
    check("s1_rdy",  {31'd0, master_rdy}, 32'h1);
    check("s1_data", master_data, 32'h1);
    m3(1'b1, 1'b1, 30'h1800_0000, 32'h0); #1;
    check("cs_s3", {25'd0, cs}, 32'h04);
    tick();
    check("s3_rdy",  {31'd0, master_rdy}, 32'h1);
    check("s3_data", master_data, 32'h3);

    // T4 internal memory write/read, top word and upper-bit aliasing
    m3(1'b1, 1'b0, 30'h005, 32'hDEAD_BEEF); #1;
    check("cs_mem", {25'd0, cs}, 32'h00);
    tick();
    check("wr_rdy",  {31'd0, master_rdy}, 32'h1);
    check("wr_data", master_data, 32'h0);
    m3(1'b1, 1'b0, 30'hFFF, 32'h1234_5678); tick();
    m3(1'b1, 1'b1, 30'h005, 32'h0); tick();
    check("rd5_rdy",  {31'd0, master_rdy}, 32'h1);
    check("rd5_data", master_data, 32'hDEAD_BEEF);
    m3(1'b1, 1'b1, 30'h0000_1FFF, 32'h0); tick();
    check("rdfff_data", master_data, 32'h1234_5678);

    // T5 parked grant, idle bus
    req = 4'b0000; m3(1'b0, 1'b1, 30'h0, 32'h0); tick();
    check("park_grnt", {28'd0, grnt}, 32'h8);
    check("idle_cs",   {25'd0, cs}, 32'h00);
    check("idle_rdy",  {31'd0, master_rdy}, 32'h0);
    check("idle_data", master_data, 32'h0);

    // T6 stall by slave 5
    req = 4'b1000; slave_5_rdy = 1'b0; m3(1'b1, 1'b1, 30'h2800_0000, 32'h0); #1;
    check("cs_s5", {25'd0, cs}, 32'h10);
    tick(); check("stall_1", {31'd0, master_rdy}, 32'h0);
    tick(); check("stall_2", {31'd0, master_rdy}, 32'h0);
    slave_5_rdy = 1'b1; #1;
    check("s5_rdy",  {31'd0, master_rdy}, 32'h1);
    check("s5_data", master_data, 32'h5);

    // Reset during a pending response
    rst_ = 1'b1; #1;
    check("midrst_rdy",  {31'd0, master_rdy}, 32'h0);
    check("midrst_grnt", {28'd0, grnt}, 32'h1);
    tick();
    rst_ = 1'b0; req = 4'b0000; m3(1'b0, 1'b0, 30'h0, 32'h0);

    // Search order from the current owner, including wrap-around
    req = 4'b1010; tick(); check("rr_to1",  {28'd0, grnt}, 32'h2);
    req = 4'b1001; tick(); check("rr_to3",  {28'd0, grnt}, 32'h8);
    req = 4'b0011; tick(); check("rr_wrap", {28'd0, grnt}, 32'h1);
    tick();               check("rr_hold", {28'd0, grnt}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
